// File: rtl/spe_accum_engine.sv
// spe_accum_engine: per-channel partial-sum FIFOs feeding a neuron accumulate/threshold engine.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   in_valid/in_ready, in_ch, in_data partial-sum input handshake (one FIFO per channel)
//   ts_done                           pulse ending the first timestep (previous potential then fetched)
//   prev_req_valid/prev_req_ready     request for the neuron's previous potential
//   prev_rsp_valid/prev_rsp_data      previous-potential response, consumed only while waiting
//   out_valid/out_ready               result handshake
//   out_potential/out_spike           residual potential and spike flag
// Build option: define SPE_LEAK_EN to subtract LEAK (floored at zero) before the threshold test.
module spe_accum_engine #(
    parameter int NUM_CH     = 5,
    parameter int SUM_WIDTH  = 13,
    parameter int FIFO_DEPTH = 6,
    parameter int THRESHOLD  = 64,
    parameter int LEAK       = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [$clog2(NUM_CH)-1:0] in_ch,
    input  logic [SUM_WIDTH-1:0]      in_data,
    input  logic                      ts_done,
    output logic                      prev_req_valid,
    input  logic                      prev_req_ready,
    input  logic                      prev_rsp_valid,
    input  logic [SUM_WIDTH-1:0]      prev_rsp_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SUM_WIDTH-1:0]      out_potential,
    output logic                      out_spike
);
    localparam int CW = $clog2(NUM_CH);
    localparam int AW = SUM_WIDTH + CW;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int NW = $clog2(FIFO_DEPTH + 1);
    localparam logic [AW:0] SAT = {{(AW + 1 - SUM_WIDTH){1'b0}}, {SUM_WIDTH{1'b1}}};

    if (THRESHOLD >= 2 ** SUM_WIDTH || THRESHOLD < 0 || LEAK < 0) begin : g_param_chk
        $error("spe_accum_engine: THRESHOLD/LEAK out of range");
    end

    typedef enum logic [2:0] {IDLE, POP, REQ, WAIT, COMPUTE, SEND} state_e;
    state_e state_q, state_d;

    logic [SUM_WIDTH-1:0] head [NUM_CH];
    logic [NUM_CH-1:0]    full, non_empty;
    logic                 pop, ch_ok;
    logic [AW-1:0]        sum_q, sum_d;
    logic [SUM_WIDTH-1:0] prev_q, pot_q, pot_d;
    logic                 spike_q, spike_d, first_ts_q;
    logic [AW:0]          raw, lk, p;

    assign pop   = state_q == POP;
    assign ch_ok = int'(in_ch) < NUM_CH;
    // A full FIFO still accepts when it is being popped in the same cycle.
    assign in_ready = rst_n && ch_ok && (!full[in_ch] || pop);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [SUM_WIDTH-1:0] mem_q [FIFO_DEPTH];
        logic [PW-1:0]        wp_q, rp_q;
        logic [NW-1:0]        cnt_q;
        logic                 push;
        assign push         = in_valid && in_ready && (in_ch == CW'(c));
        assign head[c]      = mem_q[rp_q];
        assign full[c]      = cnt_q == NW'(FIFO_DEPTH);
        assign non_empty[c] = cnt_q != '0;
        always_ff @(posedge clk) begin
            if (push) mem_q[wp_q] <= in_data;
        end
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wp_q  <= '0;
                rp_q  <= '0;
                cnt_q <= '0;
            end else begin
                if (push) wp_q <= (wp_q == PW'(FIFO_DEPTH - 1)) ? '0 : wp_q + PW'(1);
                if (pop) rp_q <= (rp_q == PW'(FIFO_DEPTH - 1)) ? '0 : rp_q + PW'(1);
                cnt_q <= cnt_q + NW'(push) - NW'(pop);
            end
        end
    end

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < NUM_CH; i++) sum_d = sum_d + AW'(head[i]);
    end

    always_comb begin
        raw = (AW + 1)'(prev_q) + (AW + 1)'(sum_q);
`ifdef SPE_LEAK_EN
        lk = (raw > (AW + 1)'(LEAK)) ? raw - (AW + 1)'(LEAK) : '0;
`else
        lk = raw;
`endif
        p       = (lk > SAT) ? SAT : lk;
        spike_d = p > (AW + 1)'(THRESHOLD);
        pot_d   = SUM_WIDTH'(spike_d ? p - (AW + 1)'(THRESHOLD) : p);
    end

    always_comb begin
        state_d        = state_q;
        prev_req_valid = 1'b0;
        out_valid      = 1'b0;
        case (state_q)
            IDLE:    state_d = &non_empty ? POP : IDLE;
            POP:     state_d = first_ts_q ? COMPUTE : REQ;
            REQ: begin
                prev_req_valid = 1'b1;
                state_d        = prev_req_ready ? WAIT : REQ;
            end
            WAIT:    state_d = prev_rsp_valid ? COMPUTE : WAIT;
            COMPUTE: state_d = SEND;
            SEND: begin
                out_valid = 1'b1;
                state_d   = out_ready ? IDLE : SEND;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            first_ts_q <= 1'b1;
            sum_q      <= '0;
            prev_q     <= '0;
            pot_q      <= '0;
            spike_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (ts_done) first_ts_q <= 1'b0;
            if (pop) begin
                sum_q <= sum_d;
                if (first_ts_q) prev_q <= '0;
            end
            if (state_q == WAIT && prev_rsp_valid) prev_q <= prev_rsp_data;
            if (state_q == COMPUTE) begin
                pot_q   <= pot_d;
                spike_q <= spike_d;
            end
        end
    end

    assign out_potential = pot_q;
    assign out_spike     = spike_q;
endmodule

// File: tb/tb_spe_accum_engine.sv
// tb_spe_accum_engine: randomized bench for spe_accum_engine with a queue-based reference model.
module tb_spe_accum_engine;
    localparam int NUM_CH = 5, SUM_WIDTH = 13, FIFO_DEPTH = 6, THRESHOLD = 64, LEAK = 1;
    localparam int MAXV = (1 << SUM_WIDTH) - 1;

    logic clk = 1'b0, rst_n, in_valid, in_ready, ts_done;
    logic [2:0] in_ch;
    logic [SUM_WIDTH-1:0] in_data, prev_rsp_data, out_potential;
    logic prev_req_valid, prev_req_ready, prev_rsp_valid, out_valid, out_ready, out_spike;

    spe_accum_engine #(.NUM_CH(NUM_CH), .SUM_WIDTH(SUM_WIDTH), .FIFO_DEPTH(FIFO_DEPTH),
                       .THRESHOLD(THRESHOLD), .LEAK(LEAK)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch),
        .in_data(in_data), .ts_done(ts_done), .prev_req_valid(prev_req_valid),
        .prev_req_ready(prev_req_ready), .prev_rsp_valid(prev_rsp_valid),
        .prev_rsp_data(prev_rsp_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_potential(out_potential), .out_spike(out_spike));

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;
    int q [NUM_CH][$];
    int prevs[$];
    bit m_first = 1'b1, rsp_real = 1'b0, hold_rsp = 1'b0;
    int n_out = 0, req_cnt = 0, last_pot = -1, last_spk = -1;
    int or_mode = 0, rsp_force = -1;
    int m_sum, m_prev, e_pot, e_spk;
    bit m_ok;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Spec rule: saturate, optional floored leak, strict threshold test.
    function automatic void model(input int prev, input int sum, output int pot, output int spk);
        int pp = prev + sum;
`ifdef SPE_LEAK_EN
        pp = pp - LEAK;
        if (pp < 0) pp = 0;
`endif
        if (pp > MAXV) pp = MAXV;
        spk = (pp > THRESHOLD) ? 1 : 0;
        pot = (spk == 1) ? pp - THRESHOLD : pp;
    endfunction

    function automatic int rand_data();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, MAXV)) : int'($urandom_range(0, 40));
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && int'(in_ch) >= NUM_CH) check("in_ready_bad_ch", in_ready, 0);
            if (in_valid && in_ready && int'(in_ch) < NUM_CH) q[int'(in_ch)].push_back(int'(in_data));
            if (prev_req_valid && prev_req_ready) req_cnt++;
            if (prev_rsp_valid && rsp_real) prevs.push_back(int'(prev_rsp_data));
            if (out_valid) begin
                m_ok = 1'b1;
                for (int c = 0; c < NUM_CH; c++) if (q[c].size() == 0) m_ok = 1'b0;
                if (!m_first && prevs.size() == 0) m_ok = 1'b0;
                if (!m_ok) check("out_unexpected", out_valid, 0);
                else begin
                    m_sum = 0;
                    for (int c = 0; c < NUM_CH; c++) m_sum += q[c][0];
                    m_prev = m_first ? 0 : prevs[0];
                    model(m_prev, m_sum, e_pot, e_spk);
                    check("potential", out_potential, e_pot);
                    check("spike", out_spike, e_spk);
                    if (out_ready) begin
                        for (int c = 0; c < NUM_CH; c++) void'(q[c].pop_front());
                        if (!m_first) void'(prevs.pop_front());
                        n_out++;
                        last_pot = int'(out_potential);
                        last_spk = int'(out_spike);
                    end
                end
            end
        end
    end

    // Previous-potential memory: random ready, delayed response, stray pulses when no request is open.
    initial begin
        int seen = 0, dly = 0;
        bit waiting = 1'b0;
        prev_req_ready = 1'b0;
        prev_rsp_valid = 1'b0;
        prev_rsp_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            prev_rsp_valid = 1'b0;
            rsp_real = 1'b0;
            if (!rst_n) begin
                waiting = 1'b0;
                seen = req_cnt;
                prev_req_ready = 1'b0;
                continue;
            end
            if (req_cnt != seen) begin
                seen = req_cnt;
                waiting = 1'b1;
                dly = $urandom_range(0, 3);
            end
            if (waiting) begin
                if (dly == 0 && !hold_rsp) begin
                    prev_rsp_valid = 1'b1;
                    rsp_real = 1'b1;
                    prev_rsp_data = SUM_WIDTH'((rsp_force >= 0) ? rsp_force : int'($urandom_range(0, MAXV)));
                    waiting = 1'b0;
                end else if (dly > 0) dly--;
            end else if ($urandom_range(0, 5) == 0) begin
                prev_rsp_valid = 1'b1;
                prev_rsp_data = SUM_WIDTH'($urandom_range(0, MAXV));
            end
            prev_req_ready = ($urandom_range(0, 1) == 1);
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = (or_mode == 0) || (or_mode == 1 && $urandom_range(0, 1) == 1);
        end
    end

    task automatic push(input int ch, input int d);
        int t = 0;
        in_valid = 1'b1;
        in_ch = 3'(ch);
        in_data = SUM_WIDTH'(d);
        @(negedge clk);
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) check("push_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic push5(input int a, input int b, input int c, input int d, input int e);
        push(0, a); push(1, b); push(2, c); push(3, d); push(4, e);
    endtask

    task automatic wait_out(input int target);
        int t = 0;
        while (n_out < target && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("results_count", n_out, target);
    endtask

    task automatic pulse_ts_done();
        ts_done = 1'b1;
        @(posedge clk);
        #1;
        ts_done = 1'b0;
    endtask

    task automatic rand_phase(input int n);
        int ch, mx, tgt;
        int def [NUM_CH];
        for (int i = 0; i < n; i++) begin
            or_mode = $urandom_range(0, 1);
            if ($urandom_range(0, 9) == 0) begin
                in_valid = 1'b1;
                in_ch = 3'($urandom_range(NUM_CH, 7));
                @(posedge clk);
                #1;
                in_valid = 1'b0;
            end else begin
                ch = $urandom_range(0, NUM_CH - 1);
                if (q[ch].size() < FIFO_DEPTH) push(ch, rand_data());
                else begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        mx = 0;
        for (int c = 0; c < NUM_CH; c++) if (q[c].size() > mx) mx = q[c].size();
        for (int c = 0; c < NUM_CH; c++) def[c] = mx - q[c].size();
        for (int c = 0; c < NUM_CH; c++) for (int k = 0; k < def[c]; k++) push(c, rand_data());
        tgt = n_out + q[0].size();
        wait_out(tgt);
        or_mode = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, r0, tgt, t;
        rst_n = 1'b0; in_valid = 1'b1; in_ch = '0; in_data = '0; ts_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_prev_req", prev_req_valid, 0);
        check("rst_potential", out_potential, 0);
        check("rst_spike", out_spike, 0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        push(0, 10); push(1, 20); push(2, 5); push(3, 15); push(4, 12);
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 20) begin
            lat++;
            @(negedge clk);
        end
        check("latency", lat, 3);
        @(posedge clk);
        #1;
        wait_out(1);
        check("ex1_potential", last_pot, 62);
        check("ex1_spike", last_spk, 0);
        push5(10, 20, 5, 15, 14);
        wait_out(2);
        check("ex2_potential", last_pot, 64);
        check("ex2_spike", last_spk, 0);

        rand_phase(150);
        check("no_req_first_ts", req_cnt, 0);

        pulse_ts_done();
        m_first = 1'b0;
        rsp_force = 30;
        r0 = req_cnt;
        tgt = n_out + 1;
        push5(10, 10, 10, 10, 10);
        wait_out(tgt);
        check("ex3_potential", last_pot, 16);
        check("ex3_spike", last_spk, 1);
        check("ex3_req_count", req_cnt - r0, 1);
        rsp_force = -1;

        tgt = n_out + 6;
        for (int k = 0; k < 6; k++) push(2, rand_data());
        in_ch = 3'd2;
        @(negedge clk);
        check("full_ch2_ready", in_ready, 0);
        in_ch = 3'd0;
        #1;
        check("empty_ch0_ready", in_ready, 1);
        @(posedge clk);
        #1;
        for (int k = 0; k < 6; k++) begin
            push(0, rand_data()); push(1, rand_data()); push(3, rand_data()); push(4, rand_data());
        end
        wait_out(tgt);

        or_mode = 2;
        @(posedge clk);
        #1;
        tgt = n_out;
        push5(rand_data(), rand_data(), rand_data(), rand_data(), rand_data());
        t = 0;
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("stall_reached", out_valid, 1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("stall_valid", out_valid, 1);
        end
        check("stall_no_accept", n_out, tgt);
        @(posedge clk);
        #1;
        push5(rand_data(), rand_data(), rand_data(), rand_data(), rand_data());
        for (int k = 0; k < 5; k++) push(0, rand_data());
        in_ch = 3'd0;
        @(negedge clk);
        check("stall_no_pop", in_ready, 0);
        @(posedge clk);
        #1;
        or_mode = 0;
        for (int k = 0; k < 5; k++) begin
            push(1, rand_data()); push(2, rand_data()); push(3, rand_data()); push(4, rand_data());
        end
        wait_out(tgt + 7);

        rand_phase(300);

        pulse_ts_done();
        r0 = req_cnt;
        tgt = n_out + 1;
        push5(rand_data(), rand_data(), rand_data(), rand_data(), rand_data());
        wait_out(tgt);
        check("ts_done_again_req", req_cnt - r0, 1);

        hold_rsp = 1'b1;
        r0 = req_cnt;
        push5(rand_data(), rand_data(), rand_data(), rand_data(), rand_data());
        t = 0;
        while (req_cnt == r0 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("wait_reached", req_cnt - r0, 1);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        in_ch = 3'd0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_prev_req", prev_req_valid, 0);
        check("midrst_potential", out_potential, 0);
        check("midrst_spike", out_spike, 0);
        check("midrst_in_ready", in_ready, 0);
        for (int c = 0; c < NUM_CH; c++) q[c].delete();
        prevs.delete();
        m_first = 1'b1;
        hold_rsp = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        r0 = req_cnt;
        tgt = n_out + 1;
        push5(1, 2, 3, 4, 5);
        wait_out(tgt);
        check("postrst_potential", last_pot, 15);
        check("postrst_spike", last_spk, 0);
        check("postrst_no_req", req_cnt - r0, 0);

        tgt = n_out + 1;
        push5(0, 0, 0, 0, 0);
        wait_out(tgt);
        check("zero_potential", last_pot, 0);
        check("zero_spike", last_spk, 0);

        pulse_ts_done();
        m_first = 1'b0;
        rsp_force = 8000;
        tgt = n_out + 1;
        push5(MAXV, MAXV, MAXV, MAXV, MAXV);
        wait_out(tgt);
        check("sat_potential", last_pot, MAXV - THRESHOLD);
        check("sat_spike", last_spk, 1);
        rsp_force = -1;

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
